// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register:
// occupancy state encodings and the RISC-V NOP used as the IF/ID bubble.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_reg_dff_en.sv
// WIDTH-bit data flop with asynchronous active-high reset and load enable.
module dff_en #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     data_q <= RST_VAL;
    else if (en) data_q <= d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, a one-beat skid buffer
// and a synchronous flush that replaces the held beats with a bubble.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             acc, dq;
  logic             main_ld, skid_ld;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  always_comb begin
    acc     = in_valid & in_ready_q;
    dq      = out_valid_q & out_ready;
    state_d = state_q;
    main_ld = 1'b0;
    main_d  = in_data;
    skid_ld = 1'b0;
    if (flush) begin
      // Same-cycle input beat is dropped; a same-cycle dq already left the stage.
      state_d = ST_EMPTY;
      main_ld = 1'b1;
      main_d  = BUBBLE_VAL;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (dq && acc) begin
            main_ld = 1'b1;
          end else if (dq) begin
            state_d = ST_EMPTY;
          end else if (acc) begin
            skid_ld = 1'b1;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (dq) begin
            main_ld = 1'b1;
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // ready is registered from the next state, so it never depends on out_ready this cycle
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  dff_en #(.WIDTH(WIDTH), .RST_VAL(RESET_VAL)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_ld),
    .d   (main_d),
    .q   (out_data)
  );

  dff_en #(.WIDTH(WIDTH), .RST_VAL(RESET_VAL)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_ld),
    .d   (in_data),
    .q   (skid_q)
  );

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign count     = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios followed by
// randomized valid/ready/flush traffic against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int          WIDTH  = 32;
  localparam logic [31:0] RST_V  = 32'hDEAD_0000;
  localparam logic [31:0] BUB_V  = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int checks   = 0;
  int failures = 0;

  // Reference model: beats held in FIFO order, and the value shown on out_data.
  logic [31:0] mq[$];
  logic [31:0] m_out;

  pipe_skid_reg #(.WIDTH(WIDTH), .RESET_VAL(RST_V), .BUBBLE_VAL(BUB_V)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, mq.size() < 2});
    chk({tag, ".count"},     {30'd0, count},     mq.size());
    chk({tag, ".out_data"},  out_data,           m_out);
    chk({tag, ".no_x"}, {31'd0, $isunknown({out_valid, in_ready, out_data, count})}, 32'd0);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  // One clock: model the edge from the specified rules, then compare at the falling edge.
  task automatic tick(input string tag);
    bit m_acc, m_dq;
    m_acc = in_valid && (mq.size() < 2);
    m_dq  = out_ready && (mq.size() > 0);
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_out = BUB_V;
    end else begin
      if (m_dq)  void'(mq.pop_front());
      if (m_acc) mq.push_back(in_data);
      if (mq.size() > 0) m_out = mq[0];
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    m_out = RST_V;
    repeat (2) @(negedge clk);
    check_all("reset_hold");
    rst = 1'b0;
    tick("after_reset");

    // Streaming 1..10 with downstream always ready
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, i, 1'b1, 1'b0);
      tick("stream");
      chk("stream.data", out_data, i);
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick("stream_drain");

    // Back-pressure: A then B with out_ready low fills the skid
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    tick("bp_a");
    drive(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    tick("bp_b");
    chk("bp.count_full", {30'd0, count}, 32'd2);
    chk("bp.ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp.head_a", out_data, 32'hAAAA_0001);
    drive(1'b1, 32'hCCCC_0003, 1'b0, 1'b0);
    tick("bp_stall");
    chk("bp.stall_a", out_data, 32'hAAAA_0001);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick("bp_rel1");
    chk("bp.then_b", out_data, 32'hBBBB_0002);
    tick("bp_rel2");

    // Flush in FULL with a live input beat C
    drive(1'b1, 32'h0000_00A1, 1'b0, 1'b0);
    tick("fl_a");
    drive(1'b1, 32'h0000_00B2, 1'b0, 1'b0);
    tick("fl_b");
    drive(1'b1, 32'h0000_00C3, 1'b0, 1'b1);
    tick("fl_full");
    chk("flush.bubble", out_data, BUB_V);
    chk("flush.count0", {30'd0, count}, 32'd0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick("fl_after");
    chk("flush.c_dropped", {31'd0, out_valid}, 32'd0);

    // Flush coincident with dq of A in ONE
    drive(1'b1, 32'h0000_0A0A, 1'b0, 1'b0);
    tick("fd_a");
    drive(1'b0, 32'd0, 1'b1, 1'b1);
    tick("fd_flush");
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick("fd_empty");
    chk("fd.empty", {31'd0, out_valid}, 32'd0);

    // Flush while empty just loads the bubble
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    tick("flush_empty");

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
            $urandom_range(0, 31) == 0);
      tick("rand");
    end

    // Asynchronous reset mid-cycle while holding beats
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    tick("ar_a");
    drive(1'b1, 32'h8765_4321, 1'b0, 1'b0);
    tick("ar_b");
    #2 rst = 1'b1;
    #1;
    mq.delete();
    m_out = RST_V;
    check_all("async_reset");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
